// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-class character LCD controller:
//   - controller and nibble-writer FSM state encodings
//   - HD44780 command constants used during configuration
//   - power-on / execution delays expressed in microseconds (the top scales
//     them to clock cycles from its CLK_HZ parameter)
//   - init nibble lookup and the "slow command" classifier
// -----------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        POWER_WAIT,
        INIT_NIB,
        CONFIG_BYTE,
        IDLE,
        BYTE_HI,
        BYTE_LO,
        EXEC_WAIT
    } lcd_state_e;

    typedef enum logic [1:0] {
        NW_IDLE,
        NW_SETUP,
        NW_PULSE
    } nw_state_e;

    // HD44780 commands
    localparam logic [7:0] FUNCTION_SET = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CLEAR        = 8'h01;
    localparam logic [7:0] HOME         = 8'h02;
    localparam logic [7:0] HOME_ALT     = 8'h03;  // bit 0 is don't-care for HOME

    // Delays in microseconds
    localparam int unsigned POWER_WAIT_US  = 15000;
    localparam int unsigned INIT_WAIT0_US  = 4100;
    localparam int unsigned INIT_WAIT1_US  = 100;
    localparam int unsigned SHORT_EXEC_US  = 40;
    localparam int unsigned NIBBLE_GAP_US  = 1;
    localparam int unsigned LONG_EXEC_US   = 1640;

    // Cycles data/RS are stable on the bus before E rises
    localparam int unsigned SETUP_CYC = 2;

    // Power-on wake-up sequence: 0x3, 0x3, 0x3 then 0x2 switches to 4-bit mode
    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    // Clear and return-home need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && ((b == CLEAR) || (b == HOME) || (b == HOME_ALT));
    endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// -----------------------------------------------------------------------------
// lcd_nibble_writer
// Issues one 4-bit strobe on the LCD bus. On a start pulse the nibble and RS
// are captured and driven, held for SETUP_CYC cycles, then E is raised for
// exactly E_CYC cycles. done pulses for one cycle in the first cycle E is low
// again. Data and RS are held until the next start.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           one-cycle request (only honoured when idle)
//   nibble, rs      value to put on the bus
//   lcd_e           LCD enable strobe
//   lcd_rs          LCD register select
//   lcd_data        LCD data nibble
//   done            one-cycle pulse after E falls
// -----------------------------------------------------------------------------
module lcd_nibble_writer #(
    parameter int unsigned E_CYC = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] nibble,
    input  logic       rs,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [3:0] lcd_data,
    output logic       done
);
    import lcd_pkg::*;

    localparam int unsigned CNT_W = $clog2(E_CYC + SETUP_CYC + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_CYC - 1);

    nw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [3:0]       data_q, data_d;
    logic             done_q, done_d;

    always_comb begin
        // NOTE: every signal gets its default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        rs_d    = rs_q;
        data_d  = data_q;
        done_d  = 1'b0;

        case (state_q)
            NW_IDLE: begin
                if (start) begin
                    data_d  = nibble;
                    rs_d    = rs;
                    cnt_d   = '0;
                    state_d = NW_SETUP;
                end
            end
            NW_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    e_d     = 1'b1;
                    state_d = NW_PULSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            NW_PULSE: begin
                if (cnt_q == E_LAST) begin
                    cnt_d   = '0;
                    e_d     = 1'b0;
                    done_d  = 1'b1;
                    state_d = NW_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = NW_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NW_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 4'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;
    assign done     = done_q;

endmodule

// File: rtl/lcd_char_controller.sv
// -----------------------------------------------------------------------------
// lcd_char_controller
// HD44780-class character LCD controller for the Spartan-3E 4-bit LCD bus.
// After reset it runs the power-on wake-up sequence and the display
// configuration (function set, entry mode, display control, clear), then
// accepts command/data bytes over a valid/ready handshake. Each byte goes out
// as upper nibble, 1 us gap, lower nibble, then the command execution wait.
//
// Ports:
//   Clock, Reset             clock, synchronous active-high reset
//   iData, iRegisterSelect   byte to write; RS 0 = command, 1 = data
//   iValid / oReady          write handshake (transfer when both high)
//   oInitDone                init + configuration finished
//   oLCD_Enabled             LCD_E
//   oLCD_RegisterSelect      LCD_RS
//   oLCD_ReadWrite           LCD_RW, tied low (write-only)
//   oLCD_StrataFlashControl  tied high to keep the shared StrataFlash off
//   oLCD_Data                SF_D<11:8>
// -----------------------------------------------------------------------------
module lcd_char_controller
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned E_CYC        = 12,
    parameter logic [7:0]  ENTRY_MODE   = 8'h06,
    parameter logic [7:0]  DISPLAY_CTRL = 8'h0C
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRegisterSelect,
    input  logic       iValid,
    output logic       oReady,
    output logic       oInitDone,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data
);

    localparam int unsigned US      = CLK_HZ / 1_000_000;
    localparam logic [31:0] T15MS   = 32'(POWER_WAIT_US * US);
    localparam logic [31:0] T4MS    = 32'(INIT_WAIT0_US * US);
    localparam logic [31:0] T100US  = 32'(INIT_WAIT1_US * US);
    localparam logic [31:0] T40US   = 32'(SHORT_EXEC_US * US);
    localparam logic [31:0] T1US    = 32'(NIBBLE_GAP_US * US);
    localparam logic [31:0] T1640US = 32'(LONG_EXEC_US * US);

    lcd_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        waiting_q, waiting_d;   // strobe finished, delay running
    logic [1:0]  idx_q, idx_d;           // init nibble / config byte index
    logic        cfg_q, cfg_d;           // byte path is sending a config byte
    logic [7:0]  byte_q, byte_d;
    logic        rs_q, rs_d;
    logic        ready_q, ready_d;
    logic        init_done_q, init_done_d;

    logic        nw_start;
    logic [3:0]  nw_nibble;
    logic        nw_rs;
    logic        nw_done;

    logic [31:0] delay;
    logic        wait_over;

    function automatic logic [7:0] config_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNCTION_SET;
            2'd1:    return ENTRY_MODE;
            2'd2:    return DISPLAY_CTRL;
            default: return CLEAR;
        endcase
    endfunction

    // Length of the delay belonging to the current state. Every delay counts
    // its first cycle as cnt 0 (or as the done cycle, see below), so the wait
    // ends in the cycle where cnt + 1 reaches the target.
    always_comb begin
        delay = T40US;
        case (state_q)
            POWER_WAIT: delay = T15MS;
            INIT_NIB: begin
                case (idx_q)
                    2'd0:    delay = T4MS;
                    2'd1:    delay = T100US;
                    default: delay = T40US;
                endcase
            end
            BYTE_HI:   delay = T1US;
            EXEC_WAIT: delay = is_long_cmd(rs_q, byte_q) ? T1640US : T40US;
            default:   delay = T40US;
        endcase
    end

    assign wait_over = (cnt_q + 32'd1) >= delay;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        waiting_d   = waiting_q;
        idx_d       = idx_q;
        cfg_d       = cfg_q;
        byte_d      = byte_q;
        rs_d        = rs_q;
        ready_d     = ready_q;
        init_done_d = init_done_q;
        nw_start    = 1'b0;
        nw_nibble   = 4'h0;
        nw_rs       = 1'b0;

        case (state_q)
            POWER_WAIT: begin
                if (wait_over) begin
                    cnt_d     = '0;
                    idx_d     = 2'd0;
                    nw_start  = 1'b1;
                    nw_nibble = init_nibble(2'd0);
                    state_d   = INIT_NIB;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            // The done cycle (first cycle with E low) is already the first
            // cycle of the following delay, hence cnt restarts at 1.
            INIT_NIB: begin
                if (nw_done) begin
                    cnt_d     = 32'd1;
                    waiting_d = 1'b1;
                end else if (waiting_q) begin
                    if (wait_over) begin
                        cnt_d     = '0;
                        waiting_d = 1'b0;
                        if (idx_q == 2'd3) begin
                            idx_d   = 2'd0;
                            state_d = CONFIG_BYTE;
                        end else begin
                            idx_d     = idx_q + 2'd1;
                            nw_start  = 1'b1;
                            nw_nibble = init_nibble(idx_q + 2'd1);
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end

            CONFIG_BYTE: begin
                byte_d    = config_byte(idx_q);
                rs_d      = 1'b0;
                cfg_d     = 1'b1;
                nw_start  = 1'b1;
                nw_nibble = config_byte(idx_q) >> 4;
                state_d   = BYTE_HI;
            end

            // The upper nibble is started on the accept edge itself so the
            // bus changes in the first cycle after the transfer.
            IDLE: begin
                if (iValid && ready_q) begin
                    byte_d    = iData;
                    rs_d      = iRegisterSelect;
                    ready_d   = 1'b0;
                    nw_start  = 1'b1;
                    nw_nibble = iData[7:4];
                    nw_rs     = iRegisterSelect;
                    state_d   = BYTE_HI;
                end
            end

            BYTE_HI: begin
                if (nw_done) begin
                    cnt_d     = 32'd1;
                    waiting_d = 1'b1;
                end else if (waiting_q) begin
                    if (wait_over) begin
                        cnt_d     = '0;
                        waiting_d = 1'b0;
                        nw_start  = 1'b1;
                        nw_nibble = byte_q[3:0];
                        nw_rs     = rs_q;
                        state_d   = BYTE_LO;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end

            BYTE_LO: begin
                if (nw_done) begin
                    cnt_d   = 32'd1;
                    state_d = EXEC_WAIT;
                end
            end

            EXEC_WAIT: begin
                if (wait_over) begin
                    cnt_d = '0;
                    if (!cfg_q) begin
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else if (idx_q == 2'd3) begin
                        cfg_d       = 1'b0;
                        idx_d       = 2'd0;
                        ready_d     = 1'b1;
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = CONFIG_BYTE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: state_d = POWER_WAIT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= POWER_WAIT;
            cnt_q       <= '0;
            waiting_q   <= 1'b0;
            idx_q       <= 2'd0;
            cfg_q       <= 1'b0;
            byte_q      <= 8'h00;
            rs_q        <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            waiting_q   <= waiting_d;
            idx_q       <= idx_d;
            cfg_q       <= cfg_d;
            byte_q      <= byte_d;
            rs_q        <= rs_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
        end
    end

    lcd_nibble_writer #(
        .E_CYC (E_CYC)
    ) u_writer (
        .clk      (Clock),
        .reset    (Reset),
        .start    (nw_start),
        .nibble   (nw_nibble),
        .rs       (nw_rs),
        .lcd_e    (oLCD_Enabled),
        .lcd_rs   (oLCD_RegisterSelect),
        .lcd_data (oLCD_Data),
        .done     (nw_done)
    );

    assign oReady                  = ready_q;
    assign oInitDone               = init_done_q;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_char_controller.sv
// -----------------------------------------------------------------------------
// tb_lcd_char_controller
// Directed bench for lcd_char_controller at CLK_HZ = 2 MHz (US = 2), which
// keeps the power-on sequence short. Derived cycle counts at 2 MHz:
//   T15MS 30000, T4MS 8200, T100US 200, T40US 80, T1US 2, T1640US 3280.
// Cycle k is the clock period following the (k-1)-th edge after the reference
// edge (accept edge or last reset edge), so a short byte shows
//   E high cycles 3..14 and 19..30, oReady back in cycle 3+12+2+2+12+80 = 111;
// a clear/home shows oReady back in cycle 31 + 3280 = 3311;
// the first power-on E rise is in cycle 30000 + 3 = 30003.
// -----------------------------------------------------------------------------
module tb_lcd_char_controller;

    localparam int unsigned T4MS_C    = 8200;
    localparam int unsigned T100US_C  = 200;
    localparam int unsigned T40US_C   = 80;
    localparam int unsigned T1640US_C = 3280;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] iData = 8'h00;
    logic       iRegisterSelect = 1'b0;
    logic       iValid = 1'b0;
    logic       oReady, oInitDone, oLCD_Enabled, oLCD_RegisterSelect;
    logic       oLCD_ReadWrite, oLCD_StrataFlashControl;
    logic [3:0] oLCD_Data;

    lcd_char_controller #(
        .CLK_HZ       (2_000_000),
        .E_CYC        (12),
        .ENTRY_MODE   (8'h06),
        .DISPLAY_CTRL (8'h0C)
    ) dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .iData                   (iData),
        .iRegisterSelect         (iRegisterSelect),
        .iValid                  (iValid),
        .oReady                  (oReady),
        .oInitDone               (oInitDone),
        .oLCD_Enabled            (oLCD_Enabled),
        .oLCD_RegisterSelect     (oLCD_RegisterSelect),
        .oLCD_ReadWrite          (oLCD_ReadWrite),
        .oLCD_StrataFlashControl (oLCD_StrataFlashControl),
        .oLCD_Data               (oLCD_Data)
    );

    always #5 Clock = ~Clock;

    int unsigned cyc = 0;
    always @(posedge Clock) cyc = cyc + 1;

    // Bus monitor: one record per completed E pulse
    typedef struct {
        logic [3:0]  d;
        logic        rs;
        int unsigned rise;
        int unsigned width;
    } nib_t;

    nib_t        nibs[$];
    nib_t        cur;
    logic        e_prev = 1'b0;
    int unsigned glitches = 0;

    always @(negedge Clock) begin
        if (oLCD_Enabled === 1'b1) begin
            if (e_prev !== 1'b1) begin
                cur.d     = oLCD_Data;
                cur.rs    = oLCD_RegisterSelect;
                cur.rise  = cyc;
                cur.width = 1;
            end else begin
                cur.width = cur.width + 1;
                if (oLCD_Data !== cur.d || oLCD_RegisterSelect !== cur.rs)
                    glitches = glitches + 1;
            end
        end else if (e_prev === 1'b1) begin
            nibs.push_back(cur);
        end
        e_prev = oLCD_Enabled;
    end

    int unsigned tests = 0;
    int unsigned failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns the cycle index (relative to ref_cyc) in which oReady is seen high, 0 on timeout
    task automatic wait_ready(input int unsigned ref_cyc, input int unsigned budget,
                              output int unsigned idx);
        int unsigned n = 0;
        idx = 0;
        while (oReady !== 1'b1 && n < budget) begin
            @(negedge Clock);
            n++;
        end
        if (oReady === 1'b1) idx = cyc - ref_cyc + 1;
    endtask

    // Called at a negedge; returns the cyc value of the accept edge
    task automatic write_byte(input logic [7:0] d, input logic rs, output int unsigned acc);
        check("ready_before_write", 32'(oReady), 32'd1);
        iData           = d;
        iRegisterSelect = rs;
        iValid          = 1'b1;
        @(negedge Clock);
        acc    = cyc;
        iValid = 1'b0;
        check("ready_low_cycle1", 32'(oReady), 32'd0);
    endtask

    // Checks the two nibbles at nibs[base] form byte exp with register select rs
    task automatic check_byte(input string tag, input int base, input logic [7:0] exp,
                              input logic rs);
        check({tag, "_present"}, 32'(nibs.size() >= base + 2), 32'd1);
        if (nibs.size() >= base + 2) begin
            check({tag, "_byte"}, {24'h0, nibs[base].d, nibs[base+1].d}, {24'h0, exp});
            check({tag, "_rs"}, {30'h0, nibs[base].rs, nibs[base+1].rs}, {30'h0, rs, rs});
            check({tag, "_ewidth"}, nibs[base].width + nibs[base+1].width, 32'd24);
        end
    endtask

    // Writes one byte and checks the bus and the oReady return cycle
    task automatic byte_test(input string tag, input logic [7:0] d, input logic rs,
                             input int unsigned ready_exp);
        int unsigned acc, idx;
        int          base;
        base = nibs.size();
        write_byte(d, rs, acc);
        wait_ready(acc, 5000, idx);
        check({tag, "_ready_cycle"}, idx, ready_exp);
        check_byte(tag, base, d, rs);
        if (nibs.size() >= base + 2) begin
            check({tag, "_hi_rise"}, nibs[base].rise - acc + 1, 32'd3);
            check({tag, "_lo_rise"}, nibs[base+1].rise - acc + 1, 32'd19);
        end
    endtask

    initial begin
        int unsigned r0, acc, idx, n, done_cyc, lost;
        int          base;
        logic        rdy, prev_rdy;
        logic [7:0]  v;
        logic [7:0]  exp_q[$];
        logic [7:0]  cfg_exp[4];

        // ---------------- reset values ----------------
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_e", 32'(oLCD_Enabled), 32'd0);
        check("rst_rs", 32'(oLCD_RegisterSelect), 32'd0);
        check("rst_data", 32'(oLCD_Data), 32'd0);
        check("rst_ready", 32'(oReady), 32'd0);
        check("rst_initdone", 32'(oInitDone), 32'd0);
        check("rst_rw", 32'(oLCD_ReadWrite), 32'd0);
        check("rst_sf", 32'(oLCD_StrataFlashControl), 32'd1);
        r0    = cyc;
        Reset = 1'b0;

        // ---------------- power-on nibbles ----------------
        n = 0;
        while (nibs.size() < 4 && n < 45000) begin
            @(negedge Clock);
            n++;
        end
        check("init_nib_count", nibs.size(), 32'd4);
        if (nibs.size() >= 4) begin
            check("init_first_rise", nibs[0].rise - r0 + 1, 32'd30003);
            check("init_nibbles", {16'h0, nibs[0].d, nibs[1].d, nibs[2].d, nibs[3].d}, 32'h3332);
            check("init_rs", {28'h0, nibs[0].rs, nibs[1].rs, nibs[2].rs, nibs[3].rs}, 32'h0);
            check("init_e_width0", nibs[0].width, 32'd12);
            check("init_gap0", 32'(nibs[1].rise - nibs[0].rise - nibs[0].width >= T4MS_C), 32'd1);
            check("init_gap1", 32'(nibs[2].rise - nibs[1].rise - nibs[1].width >= T100US_C), 32'd1);
            check("init_gap2", 32'(nibs[3].rise - nibs[2].rise - nibs[2].width >= T40US_C), 32'd1);
        end
        check("init_not_done_yet", 32'(oInitDone), 32'd0);

        // ---------------- configuration ----------------
        n        = 0;
        done_cyc = 0;
        while (oInitDone !== 1'b1 && n < 6000) begin
            @(negedge Clock);
            n++;
        end
        if (oInitDone === 1'b1) done_cyc = cyc;
        check("initdone_seen", 32'(oInitDone), 32'd1);
        check("ready_with_initdone", 32'(oReady), 32'd1);
        check("cfg_nib_count", nibs.size(), 32'd12);
        cfg_exp = '{8'h28, 8'h06, 8'h0C, 8'h01};
        for (int i = 0; i < 4; i++) check_byte($sformatf("cfg%0d", i), 4 + 2 * i, cfg_exp[i], 1'b0);
        if (nibs.size() >= 12)
            check("initdone_after_clear", done_cyc, nibs[11].rise + 12 + T1640US_C);

        // ---------------- single writes ----------------
        byte_test("wr41", 8'h41, 1'b1, 111);
        byte_test("wr01", 8'h01, 1'b0, 3311);
        byte_test("wr80", 8'h80, 1'b0, 111);
        byte_test("wr03", 8'h03, 1'b0, 3311);
        byte_test("wr04", 8'h04, 1'b0, 111);
        byte_test("wr01_data", 8'h01, 1'b1, 111);

        // ---------------- iValid held high, iData changing every cycle ----------------
        exp_q.delete();
        lost            = 0;
        prev_rdy        = 1'b0;
        base            = nibs.size();
        iValid          = 1'b1;
        iRegisterSelect = 1'b1;
        for (int k = 0; k < 400; k++) begin
            rdy = oReady;
            if (prev_rdy && rdy) lost++;
            v     = 8'(32'h20 + k);
            iData = v;
            if (rdy) exp_q.push_back(v);
            prev_rdy = rdy;
            @(negedge Clock);
        end
        iValid = 1'b0;
        wait_ready(cyc, 5000, idx);
        check("stream_ready_back", 32'(oReady), 32'd1);
        check("stream_accepts", exp_q.size(), 32'd4);
        check("stream_no_lost", lost, 32'd0);
        check("stream_nib_count", nibs.size(), 32'(base + 2 * exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check_byte($sformatf("stream%0d", i), base + 2 * i, exp_q[i], 1'b1);

        // ---------------- reset during lower-nibble E pulse ----------------
        write_byte(8'h5A, 1'b1, acc);
        n = 0;
        while (cyc - acc + 1 < 24 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        check("e_high_before_reset", 32'(oLCD_Enabled), 32'd1);
        Reset = 1'b1;
        @(negedge Clock);
        check("reset_e_low", 32'(oLCD_Enabled), 32'd0);
        check("reset_ready", 32'(oReady), 32'd0);
        check("reset_initdone", 32'(oInitDone), 32'd0);
        check("reset_data", 32'(oLCD_Data), 32'd0);
        r0    = cyc;
        Reset = 1'b0;
        n     = 0;
        while (oLCD_Enabled !== 1'b1 && n < 35000) begin
            @(negedge Clock);
            n++;
        end
        check("reinit_first_rise", cyc - r0 + 1, 32'd30003);
        check("reinit_data", 32'(oLCD_Data), 32'h3);
        check("reinit_rs", 32'(oLCD_RegisterSelect), 32'd0);
        check("reinit_ready", 32'(oReady), 32'd0);
        check("no_bus_change_while_e", glitches, 32'd0);
        check("rw_const", 32'(oLCD_ReadWrite), 32'd0);
        check("sf_const", 32'(oLCD_StrataFlashControl), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
